// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job sequencer: FSM state encoding,
// default operand width and the operand-pair record.
package gcd_pkg;

  localparam int GCD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_CLEAR  = 3'd4,
    ST_BYPASS = 3'd5,
    ST_OUT    = 3'd6
  } state_e;

  typedef struct packed {
    logic [GCD_W-1:0] a;
    logic [GCD_W-1:0] b;
  } pair_t;

endpackage

// File: rtl/gcd_job_sequencer_if.sv
// Bundles the job input port, the GCD core loading protocol and the result port.
// master = sequencer side, slave = producer/core/consumer side.
interface gcd_job_sequencer_if
  import gcd_pkg::*;
#(
  parameter int W = GCD_W
);

  logic         in_valid;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_ready;

  logic         core_start;
  logic [W-1:0] core_data_in;
  logic         core_clr_n;
  logic         core_done;
  logic [W-1:0] core_result;

  logic         out_valid;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic         out_ready;

  modport master (
    input  in_valid, in_a, in_b, core_done, core_result, out_ready,
    output in_ready, core_start, core_data_in, core_clr_n,
           out_valid, out_gcd, out_err
  );

  modport slave (
    output in_valid, in_a, in_b, core_done, core_result, out_ready,
    input  in_ready, core_start, core_data_in, core_clr_n,
           out_valid, out_gcd, out_err
  );

endinterface

// File: rtl/gcd_pair_fifo.sv
// Two-entry operand-pair FIFO with a registered occupancy count; full/empty
// are decoded from that count only, so they never depend on same-cycle push/pop.
module gcd_pair_fifo
  import gcd_pkg::*;
#(
  parameter type T = pair_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);

  T           mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset; an entry is only read once count_q says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/gcd_job_sequencer.sv
// Front-end for the GCD controller/datapath: queues operand pairs, loads the core
// (A then B), waits for done under a watchdog, clears the core and returns the result.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int TIMEOUT = 1024
) (
  input logic          clk,
  input logic          rst_n,
  gcd_job_sequencer_if.master bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } job_t;

  job_t   fifo_wdata, fifo_head;
  logic   fifo_full, fifo_empty, fifo_pop;

  state_e          state_q, state_d;
  job_t            job_q, job_d;
  logic [WD_W-1:0] wdog_q, wdog_d;

  logic            core_start_q, core_start_d;
  logic [W-1:0]    core_data_q, core_data_d;
  logic            core_clr_n_q, core_clr_n_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_gcd_q, out_gcd_d;
  logic            out_err_q, out_err_d;

  assign fifo_wdata = '{a: bus.in_a, b: bus.in_b};

  gcd_pair_fifo #(
    .T (job_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.in_valid),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.in_ready     = !fifo_full;
  assign bus.core_start   = core_start_q;
  assign bus.core_data_in = core_data_q;
  assign bus.core_clr_n   = core_clr_n_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_gcd      = out_gcd_q;
  assign bus.out_err      = out_err_q;

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    job_d     = job_q;
    wdog_d    = wdog_q;
    fifo_pop  = 1'b0;
    out_gcd_d = out_gcd_q;
    out_err_d = out_err_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          job_d    = fifo_head;
          // The core never terminates on a zero operand, so those jobs skip it.
          if (fifo_head.a == '0 || fifo_head.b == '0) state_d = ST_BYPASS;
          else                                        state_d = ST_LOAD_A;
        end
      end
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // wdog_q counts earlier WAIT cycles; done wins over a coinciding timeout.
        if (bus.core_done) begin
          out_gcd_d = bus.core_result;
          out_err_d = 1'b0;
          state_d   = ST_CLEAR;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          out_gcd_d = '0;
          out_err_d = 1'b1;
          state_d   = ST_CLEAR;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_CLEAR: state_d = ST_OUT;
      ST_BYPASS: begin
        out_gcd_d = job_q.a | job_q.b;
        out_err_d = 1'b0;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state itself.
    core_start_d = (state_d == ST_LOAD_A);
    core_clr_n_d = (state_d != ST_CLEAR);
    out_valid_d  = (state_d == ST_OUT);
    if (state_d == ST_LOAD_A)      core_data_d = job_d.a;
    else if (state_d == ST_LOAD_B) core_data_d = job_d.b;
    else                           core_data_d = core_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      job_q        <= '0;
      wdog_q       <= '0;
      core_start_q <= 1'b0;
      core_data_q  <= '0;
      core_clr_n_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_gcd_q    <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      job_q        <= job_d;
      wdog_q       <= wdog_d;
      core_start_q <= core_start_d;
      core_data_q  <= core_data_d;
      core_clr_n_q <= core_clr_n_d;
      out_valid_q  <= out_valid_d;
      out_gcd_q    <= out_gcd_d;
      out_err_q    <= out_err_d;
    end
  end

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Directed bench for gcd_job_sequencer with a behavioural GCD core that
// asserts done a programmable number of WAIT cycles after loading.
module tb_gcd_job_sequencer;
  import gcd_pkg::*;

  localparam int W   = 16;
  localparam int TMO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  gcd_job_sequencer_if #(.W(W)) bus ();

  gcd_job_sequencer #(
    .W       (W),
    .TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Core model: samples A with start, B on the next cycle, then counts WAIT cycles.
  int           phase = 0, cnt = 0, done_delay = 6;
  bit           hang = 1'b0;
  logic [W-1:0] ma = '0, mb = '0;
  int           start_cycles = 0, clr_cycles = 0, last_wait = 0;

  initial begin
    bus.core_done   = 1'b0;
    bus.core_result = '0;
  end

  always @(negedge clk) begin
    if (!rst_n || !bus.core_clr_n) begin
      if (rst_n) clr_cycles++;
      if (phase == 2) last_wait = cnt;
      phase = 0;
      bus.core_done = 1'b0;
    end else if (bus.core_start) begin
      start_cycles++;
      ma    = bus.core_data_in;
      phase = 1;
    end else if (phase == 1) begin
      mb    = bus.core_data_in;
      phase = 2;
      cnt   = 0;
    end else if (phase == 2) begin
      cnt++;
      if (!hang && cnt == done_delay) begin
        bus.core_done   = 1'b1;
        bus.core_result = gcd_f(ma, mb);
      end
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    check("push_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      step();
      n++;
    end
    check("out_valid_seen", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic expect_result(input string tag, input logic [W-1:0] g, input logic e);
    wait_valid();
    check({tag, "_gcd"}, 32'(bus.out_gcd), 32'(g));
    check({tag, "_err"}, 32'(bus.out_err), 32'(e));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  int  s0, c0;
  bit  stray;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    step();
    step();
    check("rst_in_ready",   32'(bus.in_ready),     32'd1);
    check("rst_core_start", 32'(bus.core_start),   32'd0);
    check("rst_core_data",  32'(bus.core_data_in), 32'd0);
    check("rst_core_clr_n", 32'(bus.core_clr_n),   32'd0);
    check("rst_out_valid",  32'(bus.out_valid),    32'd0);
    check("rst_out_gcd",    32'(bus.out_gcd),      32'd0);
    check("rst_out_err",    32'(bus.out_err),      32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_clr_n", 32'(bus.core_clr_n), 32'd1);

    // Single core job
    s0 = start_cycles;
    c0 = clr_cycles;
    push(16'd48, 16'd18);
    expect_result("single", 16'd6, 1'b0);
    check("single_start_cycles", 32'(start_cycles - s0), 32'd1);
    check("single_load_a",       32'(ma), 32'd48);
    check("single_load_b",       32'(mb), 32'd18);
    check("single_clr_cycles",   32'(clr_cycles - c0), 32'd1);
    check("single_wait_cycles",  32'(last_wait), 32'd6);

    // Bypass jobs never touch the core
    s0 = start_cycles;
    push(16'd0, 16'd35);
    expect_result("bypass_0_35", 16'd35, 1'b0);
    push(16'd0, 16'd0);
    expect_result("bypass_0_0", 16'd0, 1'b0);
    push(16'd21, 16'd0);
    expect_result("bypass_21_0", 16'd21, 1'b0);
    check("bypass_no_start", 32'(start_cycles - s0), 32'd0);

    // Back-to-back pushes on consecutive cycles
    check("b2b_ready0", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.in_a = 16'd12; bus.in_b = 16'd8;
    step();
    check("b2b_ready1", 32'(bus.in_ready), 32'd1);
    bus.in_a = 16'd9; bus.in_b = 16'd6;
    step();
    check("b2b_ready2", 32'(bus.in_ready), 32'd1);
    bus.in_a = 16'd7; bus.in_b = 16'd5;
    step();
    bus.in_valid = 1'b0;
    check("b2b_full", 32'(bus.in_ready), 32'd0);
    expect_result("b2b_1", 16'd4, 1'b0);
    expect_result("b2b_2", 16'd3, 1'b0);
    expect_result("b2b_3", 16'd1, 1'b0);

    // Backpressure: result held for 10 cycles while the FIFO fills
    push(16'd15, 16'd10);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        bus.in_valid = 1'b1; bus.in_a = 16'd14; bus.in_b = 16'd21;
      end else if (i == 1) begin
        bus.in_a = 16'd27; bus.in_b = 16'd18;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
      check("bp_gcd_hold",   32'(bus.out_gcd),   32'd5);
    end
    check("bp_fifo_full", 32'(bus.in_ready), 32'd0);
    expect_result("bp_1", 16'd5, 1'b0);
    expect_result("bp_2", 16'd7, 1'b0);
    expect_result("bp_3", 16'd9, 1'b0);

    // Watchdog abort after TMO WAIT cycles, then a normal job
    hang = 1'b1;
    push(16'd10, 16'd4);
    expect_result("timeout", 16'd0, 1'b1);
    check("timeout_wait_cycles", 32'(last_wait), 32'(TMO));
    hang = 1'b0;
    push(16'd10, 16'd4);
    expect_result("after_timeout", 16'd2, 1'b0);

    // done on the same cycle the watchdog expires: done wins
    done_delay = TMO;
    push(16'd36, 16'd24);
    expect_result("done_at_limit", 16'd12, 1'b0);
    check("done_at_limit_wait", 32'(last_wait), 32'(TMO));
    done_delay = 6;

    // Reset during WAIT with a further pair queued
    push(16'd48, 16'd18);
    for (int n = 0; n < 100 && !(phase == 2 && cnt >= 3); n++) step();
    check("mid_reset_in_wait", 32'(phase), 32'd2);
    push(16'd9, 16'd6);
    rst_n = 1'b0;
    #1;
    check("mid_rst_clr_n",     32'(bus.core_clr_n),   32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid),    32'd0);
    check("mid_rst_core_data", 32'(bus.core_data_in), 32'd0);
    check("mid_rst_in_ready",  32'(bus.in_ready),     32'd1);
    step();
    step();
    rst_n = 1'b1;
    s0    = start_cycles;
    stray = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.out_valid) stray = 1'b1;
    end
    check("mid_rst_no_stale",  32'(stray), 32'd0);
    check("mid_rst_no_start",  32'(start_cycles - s0), 32'd0);
    push(16'd12, 16'd8);
    expect_result("after_reset", 16'd4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
